// File: rtl/demux_rr_dispatcher_if.sv
// Handshake bundle between the upstream source, the dispatcher and the 4-way demux fabric.
// master = stimulus/fabric side, slave = dispatcher side.
interface demux_rr_dispatcher_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [3:0]       en_mask;
  logic [3:0]       out_ready;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic             s1;
  logic             s0;
  logic [CNT_W-1:0] sent_cnt;
  logic             stalled;

  modport master (
    output in_valid, in_data, en_mask, out_ready,
    input  in_ready, out_valid, out_data, s1, s0, sent_cnt, stalled
  );

  modport slave (
    input  in_valid, in_data, en_mask, out_ready,
    output in_ready, out_valid, out_data, s1, s0, sent_cnt, stalled
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher: holds one word, locks a target among enabled channels
// starting at the rotation pointer, and drives the demux select and one-hot valid.
module demux_rr_dispatcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  demux_rr_dispatcher_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, WAIT_EN, SEND} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       target;
  logic [WIDTH-1:0] buf_data;
  logic [3:0]       valid_q;
  logic             stalled_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0] base;
  logic [1:0] pick;
  logic       pick_ok;
  logic       out_fire;
  logic       in_fire;

  assign out_fire = (state == SEND) && ((valid_q & bus.out_ready) != 4'b0000);
  // A word loaded in the same cycle as a handshake scans from the post-handshake pointer.
  assign base     = out_fire ? target + 2'd1 : ptr;

  always_comb begin
    pick    = base;
    pick_ok = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pick_ok && bus.en_mask[base + 2'(i)]) begin
        pick    = base + 2'(i);
        pick_ok = 1'b1;
      end
    end
  end

  assign bus.in_ready  = rst_n && ((state == EMPTY) || out_fire);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = buf_data;
  assign bus.s1        = target[1];
  assign bus.s0        = target[0];
  assign bus.sent_cnt  = cnt;
  assign bus.stalled   = stalled_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      target    <= '0;
      buf_data  <= '0;
      valid_q   <= '0;
      stalled_q <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_fire) begin
        ptr <= target + 2'd1;
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        EMPTY, SEND: begin
          if (in_fire) begin
            buf_data <= bus.in_data;
            if (pick_ok) begin
              target    <= pick;
              valid_q   <= 4'(4'b0001 << pick);
              stalled_q <= 1'b0;
              state     <= SEND;
            end else begin
              valid_q   <= '0;
              stalled_q <= 1'b1;
              state     <= WAIT_EN;
            end
          end else if (out_fire) begin
            valid_q <= '0;
            state   <= EMPTY;
          end
        end
        WAIT_EN: begin
          if (pick_ok) begin
            target    <= pick;
            valid_q   <= 4'(4'b0001 << pick);
            stalled_q <= 1'b0;
            state     <= SEND;
          end
        end
        default: begin
          valid_q   <= '0;
          stalled_q <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Scoreboard bench for demux_rr_dispatcher: directed scenarios plus random traffic,
// checked every cycle against a word-level model of held word, lock and pointer.
module tb_demux_rr_dispatcher;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_rr_dispatcher_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  demux_rr_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         ch;
    bit         locked;
  } item_t;

  item_t q[$];
  int    m_ptr = 0;
  int    m_cnt = 0;
  int    errors = 0;
  int    checks = 0;
  logic [3:0] seen_mask = '0;
  int    last_ch = -1;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare outputs against the model, retire handshakes, then lock the held word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sel", {bus.s1, bus.s0}, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_sent_cnt", bus.sent_cnt, 0);
        chk("rst_stalled", bus.stalled, 0);
        q.delete();
        m_ptr = 0;
        m_cnt = 0;
      end else begin
        automatic bit held   = (q.size() != 0);
        automatic bit locked = held && q[0].locked;
        automatic int fire   = -1;
        if (locked) begin
          chk("out_valid", bus.out_valid, 1 << q[0].ch);
          chk("sel", {bus.s1, bus.s0}, q[0].ch);
          chk("out_data", bus.out_data, q[0].data);
          if (bus.out_ready[q[0].ch]) fire = q[0].ch;
        end else begin
          chk("out_valid_idle", bus.out_valid, 0);
        end
        chk("stalled", bus.stalled, held && !locked);
        chk("in_ready", bus.in_ready, !held || fire >= 0);
        chk("sent_cnt", bus.sent_cnt, m_cnt % (1 << CNT_W));
        seen_mask |= bus.out_valid;
        if (fire >= 0) begin
          void'(q.pop_front());
          m_ptr = (fire + 1) % 4;
          m_cnt++;
          last_ch = fire;
        end
      end
      #2;
      if (rst_n && q.size() != 0 && !q[0].locked && bus.en_mask != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          automatic int c = (m_ptr + k) % 4;
          if (!q[0].locked && bus.en_mask[c]) begin
            q[0].ch     = c;
            q[0].locked = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        #1;
        q.push_back('{data: d, ch: 0, locked: 1'b0});
        break;
      end
      n++;
      if (n > 100) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    time t0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.en_mask   = 4'b0000;
    bus.out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Full mask, all ready: rotation 0,1,2,3,0 at one word per cycle
    bus.en_mask   = 4'b1111;
    bus.out_ready = 4'b1111;
    t0 = $time;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    chk("throughput_cycles", ($time - t0) / 10, 5);
    drain();
    chk("cnt_after_5", bus.sent_cnt, 5);
    chk("last_ch_5", last_ch, 0);

    // Sparse mask: only channels 1 and 3
    bus.en_mask = 4'b1010;
    seen_mask   = '0;
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    drain();
    chk("sparse_channels", seen_mask, 4'b1010);
    chk("sparse_last_ch", last_ch, 3);

    // Zero mask stalls; enabling channel 2 at cycle K gives valid at K+1
    bus.en_mask = 4'b0000;
    send(8'hA5);
    @(negedge clk);
    chk("stall_flag", bus.stalled, 1);
    chk("stall_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.en_mask = 4'b0100;
    @(negedge clk);
    chk("wait_en_cycle_k", bus.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wait_en_k1_valid", bus.out_valid, 4'b0100);
    chk("wait_en_k1_data", bus.out_data, 8'hA5);
    @(posedge clk);
    #1;

    // Locked target 2 survives back-pressure and its mask bit being cleared
    bus.out_ready = 4'b0000;
    send(8'h5A);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.en_mask = 4'b0001;
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 4'b0100);
      chk("hold_sel", {bus.s1, bus.s0}, 2);
      chk("hold_data", bus.out_data, 8'h5A);
      chk("hold_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 4'b1011;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_nontarget_ready", q.size(), 1);
    bus.out_ready = 4'b0100;
    drain();
    chk("hold_delivered_ch", last_ch, 2);

    // Reset while a word is being offered
    bus.en_mask   = 4'b1111;
    bus.out_ready = 4'b0000;
    send(8'h3C);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_sel", {bus.s1, bus.s0}, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_cnt", bus.sent_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    send(8'h77);
    drain();
    chk("post_rst_ch", last_ch, 0);
    chk("post_rst_cnt", bus.sent_cnt, 1);

    // 17 words since reset: 4-bit counter wraps to 1
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    drain();
    chk("cnt_wrap", bus.sent_cnt, 1);

    // Random traffic, mask and back-pressure
    for (int c = 0; c < 400; c++) begin
      automatic bit acc = 1'b0;
      bus.en_mask   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      bus.out_ready = 4'($urandom);
      if (!bus.in_valid && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        #1;
        q.push_back('{data: bus.in_data, ch: 0, locked: 1'b0});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.en_mask   = 4'b1111;
    bus.out_ready = 4'b1111;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/demux_rr_dispatcher.md
# demux_rr_dispatcher

Round-robin dispatcher that sequences the 1-to-4 demultiplexer datapath. It accepts words from a single valid/ready source and routes each word to one of four destination channels. It drives the select pair (s1,s0) and exactly one channel valid, skipping disabled channels and holding each word until its destination takes it. It sits between the upstream stream source and the 4-way demux fabric, and replaces static select wiring with a scheduler.

## Interface
- WIDTH, 8, data word width in bits
- CNT_W, 16, width of dispatched-word counter

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_data  input  WIDTH  upstream word
- in_ready  output  1  dispatcher can accept a word this cycle
- en_mask  input  4  per-channel enable; bit i = channel i eligible
- out_ready  input  4  per-channel ready from destinations
- out_valid  output  4  per-channel valid, at most one bit set (one-hot or zero)
- out_data  output  WIDTH  shared data bus to all channels (demux d input)
- s1  output  1  select MSB, equal to locked target index bit 1
- s0  output  1  select LSB, equal to locked target index bit 0
- sent_cnt  output  CNT_W  count of completed output handshakes, wraps
- stalled  output  1  word held but en_mask == 0

## Operation
- Single holding register buf with data and target fields; rotation pointer ptr[1:0].
- FSM states:
  - EMPTY: buf invalid.
  - WAIT_EN: word held, no target yet because the mask was zero.
  - SEND: word held, target locked, out_valid[target] = 1.
- Target selection: first set bit of en_mask scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Evaluated with the en_mask value of the cycle it is used.
- Accept: in_fire = in_valid & in_ready. in_ready = (state == EMPTY) | out_fire. in_ready is forced 0 while rst_n is low.
- Output: out_fire = out_valid[target] & out_ready[target]. On out_fire: ptr <= target + 1 (wraps 3 -> 0), and sent_cnt increments (wraps at 2^CNT_W - 1 -> 0).
- Transitions:
  - EMPTY + in_fire: load buf. Go to SEND if en_mask != 0, with target locked from the current mask. Otherwise go to WAIT_EN.
  - WAIT_EN: when en_mask != 0, lock target and go to SEND. Otherwise stay.
  - SEND + out_fire + in_fire: load the new word. The target is computed with the updated ptr (target + 1 base). Go to SEND or WAIT_EN per the mask.
  - SEND + out_fire, no in_fire: go to EMPTY.
  - SEND, no out_fire: hold. Data, target and valid stay stable.
- Locked target is never changed by en_mask changes while in SEND. Clearing the mask bit of a locked target does not drop or reroute the word.
- Readiness of non-target channels is ignored. A word is never duplicated or lost.
- out_valid is zero in EMPTY and WAIT_EN. stalled = (state == WAIT_EN).
- s1,s0 hold the last locked target while in EMPTY and WAIT_EN. out_data holds the last buf data.

## Timing
- Reset values (asynchronous, immediate): state EMPTY, ptr 0, s1 = s0 = 0, out_valid 0, out_data 0, sent_cnt 0, stalled 0, in_ready 0 while reset is asserted. in_ready is 1 from the first cycle after rst_n deasserts.
- Latency: a word accepted at edge N drives out_valid, out_data and s1/s0 from edge N onward, visible in cycle N+1. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 word per cycle when the targeted destinations are ready (pass-through via out_fire enabling in_ready).
- WAIT_EN exit: mask nonzero in cycle K gives out_valid in cycle K+1.
- in_ready depends combinationally on out_ready. There are no other combinational input-to-output paths.
- Reset mid-operation discards the held word. sent_cnt is not incremented for it. ptr returns to 0.

## Test plan
- Reset, en_mask = 4'b1111, all out_ready = 1, words 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> targets 0, 1, 2, 3, 0. One word per cycle. sent_cnt = 5. out_valid is one-hot each cycle.
- en_mask = 4'b1010, 4 words -> targets 1, 3, 1, 3. s1/s0 match each target. Channels 0 and 2 never get valid.
- en_mask = 0, send 0xA5 -> in_ready drops and stalled = 1. Set en_mask = 4'b0100 at cycle K -> out_valid = 4'b0100 at K+1, out_data = 0xA5.
- Target 2 locked with out_ready[2] = 0 for 5 cycles, en_mask bit 2 cleared mid-wait -> out_valid, out_data and s1/s0 stay stable. in_ready = 0. Word delivered to channel 2 when out_ready[2] = 1.
- Assert rst_n low while in SEND with word 0x3C -> out_valid = 0, s1 = s0 = 0 immediately. After release, the next word goes to channel 0. sent_cnt = 0.
- CNT_W = 4, dispatch 17 words -> sent_cnt wraps to 1.
